// File: rtl/csa64_sub_pipe.sv
// csa64_sub_pipe: 64-bit subtractor (op1 - op2) built as a carry-select adder
// of op1 + ~op2 + 1, split across a three-stage valid/ready pipeline.
// S1 holds the operands, S2 holds the low 34 result bits plus the carry into
// bit 34, and S3 holds the final diff and flags that drive the outputs.

// One carry-select group: precomputes both carry-in cases and muxes on c_i.
// The lowest group (SEL=0) is a plain ripple add since its carry-in is known.
module csa64_sel_grp #(
  parameter int W   = 4,
  parameter bit SEL = 1'b1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o
);
  logic [W:0] sum0, sum1, sumc;

  // Both alternatives and the direct sum; SEL picks which path is used.
  always_comb begin
    sum0 = {1'b0, a_i} + {1'b0, b_i};
    sum1 = {1'b0, a_i} + {1'b0, b_i} + (W+1)'(1);
    sumc = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, c_i};
    if (SEL) {c_o, s_o} = c_i ? sum1 : sum0;
    else     {c_o, s_o} = sumc;
  end
endmodule

module csa64_sub_pipe (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] op1,
  input  logic [63:0] op2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] diff,
  output logic        brout,
  output logic        ovf,
  output logic        zero
);
  // Group widths, LSB first: low half covers bits 0..33, high half 34..63.
  localparam int LO_W  [6] = '{4, 4, 5, 6, 7, 8};
  localparam int LO_OFF[6] = '{0, 4, 8, 13, 19, 26};
  localparam int HI_W  [3] = '{9, 10, 11};
  localparam int HI_OFF[3] = '{0, 9, 19};

  logic        advance;
  logic        v1_q, v2_q, v3_q;
  logic [63:0] a1_q, b1_q;
  logic [33:0] dlo_q;
  logic        c34_q;
  logic [29:0] ahi_q, bhi_q;
  logic [63:0] diff_q;
  logic        brout_q, ovf_q, zero_q;

  logic [33:0] dlo_d;
  logic [29:0] dhi_d;
  logic [6:0]  lc;
  logic [3:0]  hc;
  logic [63:0] bn1;
  logic [29:0] bnhi;

  // Whole-pipe advance: any empty or draining S3 lets every stage move.
  always_comb begin
    advance  = !v3_q || out_ready;
    in_ready = advance && !reset;
  end

  // Subtrahend inverted; the +1 enters as carry-in of the lowest group.
  always_comb begin
    bn1  = ~b1_q;
    bnhi = ~bhi_q;
  end

  assign lc[0] = 1'b1;
  assign hc[0] = c34_q;

  genvar g;
  generate
    for (g = 0; g < 6; g++) begin : g_lo
      csa64_sel_grp #(.W(LO_W[g]), .SEL(g != 0)) u_grp (
        .a_i(a1_q[LO_OFF[g] +: LO_W[g]]),
        .b_i(bn1[LO_OFF[g] +: LO_W[g]]),
        .c_i(lc[g]),
        .s_o(dlo_d[LO_OFF[g] +: LO_W[g]]),
        .c_o(lc[g+1])
      );
    end
    for (g = 0; g < 3; g++) begin : g_hi
      csa64_sel_grp #(.W(HI_W[g]), .SEL(1'b1)) u_grp (
        .a_i(ahi_q[HI_OFF[g] +: HI_W[g]]),
        .b_i(bnhi[HI_OFF[g] +: HI_W[g]]),
        .c_i(hc[g]),
        .s_o(dhi_d[HI_OFF[g] +: HI_W[g]]),
        .c_o(hc[g+1])
      );
    end
  endgenerate

  // S1: capture operands on acceptance; valid follows the handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1_q <= 1'b0;
      a1_q <= '0;
      b1_q <= '0;
    end else if (advance) begin
      v1_q <= in_valid && in_ready;
      if (in_valid && in_ready) begin
        a1_q <= op1;
        b1_q <= op2;
      end
    end
  end

  // S2: low 34 result bits, carry into bit 34, and the untouched high operands.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v2_q  <= 1'b0;
      dlo_q <= '0;
      c34_q <= 1'b0;
      ahi_q <= '0;
      bhi_q <= '0;
    end else if (advance) begin
      v2_q  <= v1_q;
      dlo_q <= dlo_d;
      c34_q <= lc[6];
      ahi_q <= a1_q[63:34];
      bhi_q <= b1_q[63:34];
    end
  end

  // S3: final difference and flags; outputs come straight from here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v3_q    <= 1'b0;
      diff_q  <= '0;
      brout_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (advance) begin
      v3_q    <= v2_q;
      diff_q  <= {dhi_d, dlo_q};
      brout_q <= ~hc[3];
      ovf_q   <= (ahi_q[29] != bhi_q[29]) && (dhi_d[29] != ahi_q[29]);
      zero_q  <= ({dhi_d, dlo_q} == 64'd0);
    end
  end

  assign out_valid = v3_q;
  assign diff      = diff_q;
  assign brout     = brout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_csa64_sub_pipe.sv
// Directed bench for csa64_sub_pipe: reset values, latency, borrow/overflow/
// zero corner cases, mid-flight reset and a backpressured burst.
module tb_csa64_sub_pipe;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] op1 = '0, op2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] diff;
  logic        brout, ovf, zero;

  int n_cmp = 0;
  int n_err = 0;

  csa64_sub_pipe dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .brout(brout), .ovf(ovf), .zero(zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Single pair: accept, confirm 3-cycle latency, then check result fields.
  task automatic run1(input string tag, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] ed, input logic eb, input logic eo, input logic ez);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op1 = a;
    op2 = b;
    #1 chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    @(negedge clock);
    in_valid = 1'b0;
    op1 = $urandom;
    op2 = $urandom;
    @(negedge clock);
    chk({tag, "_early"}, 64'(out_valid), 64'd0);
    @(negedge clock);
    chk({tag, "_vld"}, 64'(out_valid), 64'd1);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_flags"}, {61'd0, brout, ovf, zero}, {61'd0, eb, eo, ez});
    @(negedge clock);
    chk({tag, "_drain"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int sent, got, extra;
    logic [63:0] hold_d;
    logic        hold_v;

    // Reset with garbage on the inputs.
    in_valid = 1'b1;
    op1 = {$urandom, $urandom};
    op2 = {$urandom, $urandom};
    out_ready = 1'($urandom);
    repeat (3) @(negedge clock);
    chk("rst_out", {diff[63:0]}, 64'd0);
    chk("rst_flags", {60'd0, brout, ovf, zero, out_valid}, 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    reset = 1'b0;
    #1 chk("post_rst_rdy", 64'(in_ready), 64'd1);
    @(negedge clock);

    run1("basic",  64'h10, 64'h3, 64'hD, 1'b0, 1'b0, 1'b0);
    run1("borrow", 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run1("c34",    64'h0000_0004_0000_0000, 64'h1, 64'h0000_0003_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run1("ovf",    64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
    run1("zero",   64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 64'h0, 1'b0, 1'b0, 1'b1);
    run1("ovfbr",  64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0);

    // Backpressured burst: 5 pairs back to back, out_ready low in cycles 4-5.
    sent = 0;
    got  = 0;
    hold_d = '0;
    hold_v = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      out_ready = !(cyc == 4 || cyc == 5);
      in_valid  = (sent < 5);
      op1 = 64'(sent + 10);
      op2 = 64'(sent);
      #1;
      if (cyc == 4) begin
        chk("bp_stall_rdy0", 64'(in_ready), 64'd0);
        hold_d = diff;
        hold_v = out_valid;
      end
      if (cyc == 5) begin
        chk("bp_stall_rdy1", 64'(in_ready), 64'd0);
        chk("bp_hold", {diff}, hold_d);
        chk("bp_hold_v", 64'(out_valid), 64'(hold_v));
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk($sformatf("bp_res%0d", got), diff, 64'd10);
        got++;
      end
      @(negedge clock);
    end
    chk("bp_count", 64'(got), 64'd5);
    in_valid = 1'b0;
    out_ready = 1'b1;
    extra = 0;
    repeat (5) begin
      #1 if (out_valid) extra++;
      @(negedge clock);
    end
    chk("bp_no_dup", 64'(extra), 64'd0);

    // Reset mid-flight: in-flight pair must vanish immediately and never return.
    in_valid = 1'b1;
    op1 = 64'h55;
    op2 = 64'h5;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    #1 chk("mid_rst_vld", 64'(out_valid), 64'd0);
    chk("mid_rst_rdy", 64'(in_ready), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    extra = 0;
    repeat (5) begin
      #1 if (out_valid) extra++;
      @(negedge clock);
    end
    chk("mid_rst_lost", 64'(extra), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
